// File: rtl/isa_io_responder.sv
// ISA I/O target for the SM2201 board: decodes an 8-register window,
// stretches hit cycles with CHRDY and bridges them to one-cycle core strobes.
module isa_io_responder #(
  parameter logic [9:0] BASE_ADDR   = 10'h100,
  parameter int         WAIT_STATES = 3
) (
  input  logic       isa_clk,
  input  logic       isa_reset,
  input  logic [9:0] isa_addr,
  input  logic       isa_ale,
  input  logic       isa_aen,
  input  logic       isa_ior,
  input  logic       isa_iow,
  input  logic [7:0] isa_data_in,
  output logic [7:0] isa_data_out,
  output logic       isa_data_oe,
  output logic       isa_chrdy,
  output logic [2:0] reg_addr,
  output logic       reg_rd_strobe,
  input  logic [7:0] reg_rd_data,
  output logic       reg_wr_strobe,
  output logic [7:0] reg_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_REQ, S_RD_CAP, S_HOLD, S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(WAIT_STATES - 1);

  state_t     r_state, w_state_n;
  logic [1:0] r_ior_sync, r_iow_sync;
  logic       r_hit;
  logic [2:0] r_reg_addr;
  logic       r_rd, w_rd_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic       r_chrdy, w_chrdy_n;
  logic       r_oe, w_oe_n;
  logic [7:0] r_dout, w_dout_n;
  logic       r_rd_stb, w_rd_stb_n;
  logic       r_wr_stb, w_wr_stb_n;
  logic [7:0] r_wr_data, w_wr_data_n;

  logic w_ior_s, w_iow_s, w_act_high;

  assign w_ior_s    = r_ior_sync[1];
  assign w_iow_s    = r_iow_sync[1];
  assign w_act_high = r_rd ? w_ior_s : w_iow_s;

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_ior_sync <= 2'b11;
      r_iow_sync <= 2'b11;
    end else begin
      r_ior_sync <= {r_ior_sync[0], isa_ior};
      r_iow_sync <= {r_iow_sync[0], isa_iow};
    end
  end

  // Decode is frozen while a cycle is in flight.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_hit      <= 1'b0;
      r_reg_addr <= 3'd0;
    end else if (isa_ale && r_state == S_IDLE) begin
      r_hit      <= !isa_aen && (isa_addr[9:3] == BASE_ADDR[9:3]);
      r_reg_addr <= isa_addr[2:0];
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_rd_n      = r_rd;
    w_cnt_n     = r_cnt;
    w_chrdy_n   = r_chrdy;
    w_oe_n      = r_oe;
    w_dout_n    = r_dout;
    w_rd_stb_n  = 1'b0;
    w_wr_stb_n  = 1'b0;
    w_wr_data_n = r_wr_data;
    unique case (r_state)
      S_IDLE: begin
        if (!w_ior_s && !w_iow_s) begin
          w_state_n = S_DONE;
        end else if (!w_ior_s && r_hit) begin
          w_state_n = S_WAIT;
          w_rd_n    = 1'b1;
          w_cnt_n   = 4'd0;
          w_chrdy_n = 1'b0;
        end else if (!w_iow_s && r_hit) begin
          w_state_n   = S_WAIT;
          w_rd_n      = 1'b0;
          w_cnt_n     = 4'd0;
          w_chrdy_n   = 1'b0;
          w_wr_data_n = isa_data_in;
        end
      end
      S_WAIT: begin
        if (w_act_high) begin
          w_state_n = S_IDLE;
          w_chrdy_n = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          if (r_rd) begin
            w_state_n = S_RD_REQ;
          end else begin
            w_state_n  = S_HOLD;
            w_wr_stb_n = 1'b1;
            w_chrdy_n  = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 4'd1;
        end
      end
      S_RD_REQ: begin
        w_rd_stb_n = 1'b1;
        w_state_n  = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_dout_n  = reg_rd_data;
        w_oe_n    = 1'b1;
        w_chrdy_n = 1'b1;
        w_state_n = S_HOLD;
      end
      S_HOLD: begin
        if (w_act_high) begin
          w_oe_n    = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      S_DONE: begin
        if (w_ior_s && w_iow_s) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_state   <= S_IDLE;
      r_rd      <= 1'b0;
      r_cnt     <= 4'd0;
      r_chrdy   <= 1'b1;
      r_oe      <= 1'b0;
      r_dout    <= 8'd0;
      r_rd_stb  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_data <= 8'd0;
    end else begin
      r_state   <= w_state_n;
      r_rd      <= w_rd_n;
      r_cnt     <= w_cnt_n;
      r_chrdy   <= w_chrdy_n;
      r_oe      <= w_oe_n;
      r_dout    <= w_dout_n;
      r_rd_stb  <= w_rd_stb_n;
      r_wr_stb  <= w_wr_stb_n;
      r_wr_data <= w_wr_data_n;
    end
  end

  assign isa_data_out  = r_dout;
  assign isa_data_oe   = r_oe;
  assign isa_chrdy     = r_chrdy;
  assign reg_addr      = r_reg_addr;
  assign reg_rd_strobe = r_rd_stb;
  assign reg_wr_strobe = r_wr_stb;
  assign reg_wr_data   = r_wr_data;

endmodule
